// File: rtl/sort_pkg.sv
// Shared types and sizing for the sort4 engine: FSM states and default batch geometry.
package sort_pkg;

  localparam int W_DEF = 4;
  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int sort_cycles(input int n);
    return n * (n - 1) / 2;
  endfunction

  localparam int SORT_CYCLES = sort_cycles(N_DEF);
  localparam int IDX_W       = $clog2(N_DEF);

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-and-swap: reports a > b and presents the pair in ascending order.
module cmp_swap #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  assign gt = a > b;
  assign lo = gt ? b : a;
  assign hi = gt ? a : b;

endmodule

// File: rtl/sort4_engine.sv
// Batch bubble sorter: loads N operands, runs N(N-1)/2 compare-and-swap cycles,
// then streams the batch out in ascending order with a last flag on the largest.
module sort4_engine
  import sort_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

  state_t        state;
  logic [W-1:0]  elem [N];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] j;
  logic [IW-1:0] pass;

  logic [IW-1:0] j_next;
  logic [IW-1:0] j_end;
  logic          gt;
  logic [W-1:0]  lo;
  logic [W-1:0]  hi;

  // Each pass bubbles the largest remaining value to the top, so the window shrinks by one.
  assign j_next = j + IW'(1);
  assign j_end  = LAST_PASS - pass;

  cmp_swap #(.W(W)) u_cmp (
    .a  (elem[j]),
    .b  (elem[j_next]),
    .gt (gt),
    .lo (lo),
    .hi (hi)
  );

  assign in_ready  = (state == LOAD);
  assign busy      = (state == SORT);
  assign out_valid = (state == OUT);
  assign out_data  = out_valid ? elem[rd_idx] : '0;
  assign out_last  = out_valid && (rd_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD;
      wr_idx <= '0;
      rd_idx <= '0;
      j      <= '0;
      pass   <= '0;
      for (int i = 0; i < N; i++) begin
        elem[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            elem[wr_idx] <= in_data;
            if (wr_idx == LAST_IDX) begin
              wr_idx <= '0;
              j      <= '0;
              pass   <= '0;
              state  <= SORT;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end
        SORT: begin
          if (gt) begin
            elem[j]      <= lo;
            elem[j_next] <= hi;
          end
          // Fixed schedule: every pass runs to its end, so latency never depends on data.
          if (j == j_end) begin
            j <= '0;
            if (pass == LAST_PASS) begin
              pass   <= '0;
              rd_idx <= '0;
              state  <= OUT;
            end else begin
              pass <= pass + IW'(1);
            end
          end else begin
            j <= j_next;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx <= '0;
              wr_idx <= '0;
              state  <= LOAD;
            end else begin
              rd_idx <= rd_idx + IW'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_engine.sv
// Scoreboard bench for sort4_engine: expected sorted batches are queued when loaded
// and checked as each output handshake is observed.
module tb_sort4_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;
  logic       busy;

  typedef struct packed {
    logic [3:0] data;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  int   acc_cycle = 0;
  int   rise_cycle = -1;
  int   busy_cnt = 0;
  logic prev_out_valid = 1'b0;

  sort4_engine #(.W(4), .N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Monitor samples on the falling edge, between the bench's drive point and the next active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (out_valid && !prev_out_valid) rise_cycle = cycle;
      if (in_valid && (busy || out_valid)) checkOutput("in_ready_outside_load", int'(in_ready), 0);
      if (!out_valid) checkOutput("out_data_idle_zero", int'(out_data), 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", int'(out_data), -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("out_data", int'(out_data), int'(e.data));
          checkOutput("out_last", int'(out_last), int'(e.last));
        end
      end
    end
    prev_out_valid = out_valid;
  end

  task automatic pushExpected(input logic [3:0] a, b, c, d);
    sb.push_back('{data: a, last: 1'b0});
    sb.push_back('{data: b, last: 1'b0});
    sb.push_back('{data: c, last: 1'b0});
    sb.push_back('{data: d, last: 1'b1});
  endtask

  task automatic applyStimulus(input logic [3:0] a, b, c, d, input int gap, input logic keep_valid);
    logic [3:0] v [4];
    int   k;
    int   guard;
    logic accepted;
    v = '{a, b, c, d};
    k = 0;
    guard = 0;
    busy_cnt = 0;
    rise_cycle = -1;
    while (k < 4 && guard < 200) begin
      in_valid = 1'b1;
      in_data  = v[k];
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk); #1;
      guard++;
      if (accepted) begin
        k++;
        if (k == 4) begin
          acc_cycle = cycle;
        end else if (gap > 0) begin
          in_valid = 1'b0;
          repeat (gap) begin
            @(posedge clk); #1;
          end
        end
      end
    end
    if (k < 4) checkOutput("load_timeout", k, 4);
    in_valid = keep_valid;
    in_data  = 4'h5;
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) checkOutput("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat1;
    int guard;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 4'h0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_data", int'(out_data), 0);
    checkOutput("reset_out_last", int'(out_last), 0);
    checkOutput("reset_busy", int'(busy), 0);

    // Batch with duplicates
    pushExpected(3, 3, 9, 12);
    applyStimulus(9, 3, 12, 3, 0, 1'b0);
    waitDrain();
    checkOutput("t1_busy_cycles", busy_cnt, 6);
    checkOutput("t1_latency", rise_cycle - acc_cycle, 6);

    // Already sorted, then reversed
    pushExpected(1, 2, 3, 4);
    applyStimulus(1, 2, 3, 4, 0, 1'b0);
    waitDrain();
    lat1 = rise_cycle - acc_cycle;
    checkOutput("t2_sorted_latency", lat1, 6);
    pushExpected(0, 5, 10, 15);
    applyStimulus(15, 10, 5, 0, 0, 1'b0);
    waitDrain();
    checkOutput("t2_reversed_latency", rise_cycle - acc_cycle, lat1);
    checkOutput("t2_reversed_busy", busy_cnt, 6);

    // Gapped input, in_valid held high through SORT and OUT
    pushExpected(0, 0, 15, 15);
    applyStimulus(0, 15, 0, 15, 2, 1'b1);
    waitDrain();
    in_valid = 1'b0;
    checkOutput("t3_in_ready_after", int'(in_ready), 1);

    // Output back-pressure while out_data=2
    out_ready = 1'b0;
    pushExpected(1, 2, 5, 7);
    applyStimulus(7, 2, 5, 1, 0, 1'b0);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("t4_out_valid_seen", int'(out_valid), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checkOutput("t4_stall_valid", int'(out_valid), 1);
      checkOutput("t4_stall_data", int'(out_data), 2);
      checkOutput("t4_stall_last", int'(out_last), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    waitDrain();

    // Reset during the third sort cycle discards the batch
    applyStimulus(8, 6, 4, 2, 0, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    checkOutput("t5_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("t5_rst_in_ready", int'(in_ready), 1);
    checkOutput("t5_rst_out_valid", int'(out_valid), 0);
    checkOutput("t5_rst_busy", int'(busy), 0);
    pushExpected(0, 1, 2, 3);
    applyStimulus(3, 1, 2, 0, 0, 1'b0);
    waitDrain();

    // Back-to-back batches
    pushExpected(1, 3, 6, 8);
    applyStimulus(6, 1, 8, 3, 0, 1'b0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(out_valid && out_last) && guard < 50);
    checkOutput("t6_last_seen", int'(out_valid && out_last), 1);
    @(posedge clk); #1;
    checkOutput("t6_b2b_in_ready", int'(in_ready), 1);
    pushExpected(4, 4, 4, 4);
    applyStimulus(4, 4, 4, 4, 0, 1'b0);
    waitDrain();
    checkOutput("t6_latency", rise_cycle - acc_cycle, 6);
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
